frame_writer: RTL
=================

# frame_writer

Camera-side capture engine for the single-buffer frame path. Converts a byte-serial camera stream (vsync/href/8-bit data, two bytes per RGB565 pixel) into sequential 16-bit writes into the frame buffer RAM. It drives the `pixel_vsync` frame-complete indication consumed by the single-buffer controller, and honours that controller's `select` output. It captures exactly one frame per reset.

## Interface
- `VSYNC_ACTIVE`, 0, level driven on `pixel_vsync` when a frame is complete; idle level is `~VSYNC_ACTIVE`.
- `ADDR_W`, 17, buffer address width; must satisfy 2^ADDR_W >= `FRAME_PIXELS`.
- `FRAME_PIXELS`, 76800, buffer capacity in pixels (320x240).
- `clk`  in  1  single system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `select`  in  1  from buffer controller: 0 = buffer owned by writer, 1 = frame held (writer must not write).
- `cam_vsync`  in  1  camera vsync, high during vertical blank.
- `cam_href`  in  1  camera line valid, one byte per `clk` while high.
- `cam_data`  in  8  camera byte.
- `wr_en`  out  1  one-cycle RAM write strobe.
- `wr_addr`  out  ADDR_W  RAM write address.
- `wr_data`  out  16  pixel, `{first_byte, second_byte}`.
- `pixel_vsync`  out  1  frame-complete indication to controller.
- `frame_overflow`  out  1  sticky: frame exceeded `FRAME_PIXELS`.

## Operation
- Input stage: `cam_vsync`, `cam_href`, `cam_data` registered once (`_q`); FSM and edge detection use `_q` only.
- States:
  - **WAIT_VS**: wait for `cam_vsync_q` high (blank), guaranteeing capture starts at a frame boundary.
  - **WAIT_START**: on `cam_vsync_q` high-to-low with `select==0` -> CAPTURE. If `select==1`, stay.
  - **CAPTURE**: pair bytes while `cam_href_q` high.
  - **DONE**: terminal until `reset`.
- Byte phase toggles per byte with `cam_href_q` high; cleared whenever `cam_href_q` low.
  - First byte latched into high half.
  - Second byte completes the pixel: `wr_en`=1, `wr_data`={hi,lo}, `wr_addr`=pixel count; count increments after the write.
  - A pending first byte at href fall is discarded.
- Pixel count saturates at `FRAME_PIXELS`. Further completed pixels are dropped (no `wr_en`) and `frame_overflow` is set.
- Frame end: `cam_vsync_q` low-to-high in CAPTURE -> DONE, `pixel_vsync`=`VSYNC_ACTIVE`, held until reset.
- `select` rising to 1 during CAPTURE: suppress all further `wr_en` and go to DONE immediately.
- Simultaneous vsync rise and pixel completion in the same cycle: vsync wins, pixel not written.
- Zero-pixel frame (vsync cycle with no href): DONE with `wr_addr` 0, no writes.

## Timing
- Reset values:
  - `wr_en`=0, `wr_addr`=0, `wr_data`=0.
  - `pixel_vsync`=`~VSYNC_ACTIVE`, `frame_overflow`=0.
  - State WAIT_VS, byte phase 0, count 0.
- Reset mid-frame: all of the above on the next edge; the partial frame is abandoned.
- Latency: second byte present at inputs before edge k -> `wr_en`/`wr_addr`/`wr_data` valid after edge k+1, for exactly one cycle.
- `wr_addr` and `wr_data` hold their last written values when `wr_en`=0.
- Vsync rise present before edge k -> `pixel_vsync` active after edge k+1.
- Maximum throughput: one pixel per two cycles.

## Configuration
- `FRAME_WRITER_DECIMATE_EN` defined:
  - Writes only even-indexed pixels of even-indexed lines (2x2 decimation).
  - The line index counts href falling edges from frame start, with the first line indexed 0.
  - The pixel index within a line resets at each href rise.
  - Dropped pixels do not advance `wr_addr` and do not count toward overflow.
- Undefined: every pixel written; no line counter logic present.

## Test plan
- Frame of 2 lines x 4 bytes (`FRAME_PIXELS`=16), bytes 0x01..0x08:
  - Four writes: addr 0..3, data 0x0102, 0x0304, 0x0506, 0x0708.
  - `pixel_vsync`=`VSYNC_ACTIVE` two cycles after the vsync rise.
- Line of 5 bytes 0xA0..0xA4: writes 0xA0A1, 0xA2A3 only; 0xA4 discarded; the next line's first pixel pairs fresh bytes.
- `FRAME_PIXELS`=4, frame of 6 pixels:
  - Writes at addr 0..3 only, `frame_overflow`=1.
  - DONE at vsync rise.
- `select`=1 held at frame start: no writes, state remains WAIT_START. After `select` falls, capture begins at the next vsync fall.
- Reset asserted mid-line after 3 pixels: next cycle `wr_en`=0, `wr_addr`=0, `pixel_vsync` inactive. A new frame writes from addr 0.
- With `FRAME_WRITER_DECIMATE_EN`, 4 lines x 4 pixels: 4 writes, taken from pixels (0,0), (0,2), (2,0), (2,2), at addr 0..3.

Source files
------------

// File: rtl/frame_writer.sv
// frame_writer: byte-serial RGB565 camera capture into a single frame buffer.
// Pairs camera bytes into 16-bit pixels, writes them at sequential addresses,
// and flags frame completion on pixel_vsync. One frame is captured per reset.
// Optional build macro: FRAME_WRITER_DECIMATE_EN (2x2 decimation, keeps even
// pixels of even lines).
module frame_writer #(
  parameter logic VSYNC_ACTIVE = 1'b0,
  parameter int   ADDR_W       = 17,
  parameter int   FRAME_PIXELS = 76800
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              select,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              pixel_vsync,
  output logic              frame_overflow
);

  // Count is one bit wider than the address so it can hold FRAME_PIXELS itself.
  localparam logic [ADDR_W:0] FRAME_LIMIT = (ADDR_W+1)'(FRAME_PIXELS);

  typedef enum logic [1:0] {WAIT_VS, WAIT_START, CAPTURE, DONE} state_t;

  state_t            state_reg, state_next;
  logic              cam_vsync_q, cam_href_q;
  logic [7:0]        cam_data_q;
  logic              vsync_prev_reg;
  logic              phase_reg, phase_next;
  logic [7:0]        hi_reg, hi_next;
  logic [ADDR_W:0]   count_reg, count_next;
  logic              wr_en_reg, wr_en_next;
  logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
  logic [15:0]       wr_data_reg, wr_data_next;
  logic              pixel_vsync_reg, pixel_vsync_next;
  logic              overflow_reg, overflow_next;
  logic              keep_pixel;
  logic              vs_rise, vs_fall;

  assign vs_rise = cam_vsync_q & ~vsync_prev_reg;
  assign vs_fall = ~cam_vsync_q & vsync_prev_reg;

`ifdef FRAME_WRITER_DECIMATE_EN
  logic href_prev_reg;
  logic line_odd_reg, line_odd_next;
  logic pix_odd_reg, pix_odd_next;

  // Only the parity of the line and pixel indices matters for 2x2 decimation.
  always_ff @(posedge clk) begin
    if (reset) begin
      href_prev_reg <= 1'b0;
      line_odd_reg  <= 1'b0;
      pix_odd_reg   <= 1'b0;
    end else begin
      href_prev_reg <= cam_href_q;
      line_odd_reg  <= line_odd_next;
      pix_odd_reg   <= pix_odd_next;
    end
  end

  // Track line parity (href falls) and pixel parity (cleared at href rise).
  always_comb begin
    line_odd_next = line_odd_reg;
    pix_odd_next  = pix_odd_reg;
    keep_pixel    = ~line_odd_reg & ~pix_odd_reg;
    if (state_reg == WAIT_START) begin
      line_odd_next = 1'b0;
      pix_odd_next  = 1'b0;
    end else if (state_reg == CAPTURE) begin
      if (href_prev_reg && !cam_href_q) line_odd_next = ~line_odd_reg;
      if (cam_href_q && !href_prev_reg) pix_odd_next = 1'b0;
      else if (cam_href_q && phase_reg) pix_odd_next = ~pix_odd_reg;
    end
  end
`else
  assign keep_pixel = 1'b1;
`endif

  // Input stage: register the camera signals once before any decision.
  always_ff @(posedge clk) begin
    if (reset) begin
      cam_vsync_q    <= 1'b0;
      cam_href_q     <= 1'b0;
      cam_data_q     <= 8'h00;
      vsync_prev_reg <= 1'b0;
    end else begin
      cam_vsync_q    <= cam_vsync;
      cam_href_q     <= cam_href;
      cam_data_q     <= cam_data;
      vsync_prev_reg <= cam_vsync_q;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= WAIT_VS;
    else       state_reg <= state_next;
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_reg       <= 1'b0;
      hi_reg          <= 8'h00;
      count_reg       <= '0;
      wr_en_reg       <= 1'b0;
      wr_addr_reg     <= '0;
      wr_data_reg     <= 16'h0000;
      pixel_vsync_reg <= ~VSYNC_ACTIVE;
      overflow_reg    <= 1'b0;
    end else begin
      phase_reg       <= phase_next;
      hi_reg          <= hi_next;
      count_reg       <= count_next;
      wr_en_reg       <= wr_en_next;
      wr_addr_reg     <= wr_addr_next;
      wr_data_reg     <= wr_data_next;
      pixel_vsync_reg <= pixel_vsync_next;
      overflow_reg    <= overflow_next;
    end
  end

  // Next-state and datapath logic; frame end and select take priority over pixels.
  always_comb begin
    state_next       = state_reg;
    phase_next       = 1'b0;
    hi_next          = hi_reg;
    count_next       = count_reg;
    wr_en_next       = 1'b0;
    wr_addr_next     = wr_addr_reg;
    wr_data_next     = wr_data_reg;
    pixel_vsync_next = pixel_vsync_reg;
    overflow_next    = overflow_reg;
    case (state_reg)
      WAIT_VS: begin
        if (cam_vsync_q) state_next = WAIT_START;
      end
      WAIT_START: begin
        if (vs_fall && !select) state_next = CAPTURE;
      end
      CAPTURE: begin
        if (select) begin
          // Controller took the buffer: stop writing. This is an abort, not a
          // completed frame, so pixel_vsync is left idle.
          state_next = DONE;
        end else if (vs_rise) begin
          state_next       = DONE;
          pixel_vsync_next = VSYNC_ACTIVE;
        end else if (cam_href_q) begin
          if (!phase_reg) begin
            hi_next    = cam_data_q;
            phase_next = 1'b1;
          end else if (keep_pixel) begin
            if (count_reg < FRAME_LIMIT) begin
              wr_en_next   = 1'b1;
              wr_addr_next = count_reg[ADDR_W-1:0];
              wr_data_next = {hi_reg, cam_data_q};
              count_next   = count_reg + (ADDR_W+1)'(1);
            end else begin
              overflow_next = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  assign wr_en          = wr_en_reg;
  assign wr_addr        = wr_addr_reg;
  assign wr_data        = wr_data_reg;
  assign pixel_vsync    = pixel_vsync_reg;
  assign frame_overflow = overflow_reg;

endmodule
